maquina_planta: RTL and testbench
=================================

# maquina_planta

Behavioural-synthesizable plant model of the washing-machine drum, placed at the opposite end of the controller/sensor interface from the `maquina` controller. Consumes the controller's actuator commands (fill valve, wash motor, spin motor, drain pump) and produces the sensor signals the controller consumes: `cheio`, `tempo` and `secar`. Lets the controller run closed-loop in simulation and on the FPGA board without a real drum.

## Interface
- `NIVEL_MAX`, default 8: drum level count at which the drum is full; must be ≥ 1.
- `T_LAVAGEM`, default 12: wash duration in clock cycles; must be ≥ 1.
- `T_CENTRIF`, default 6: spin duration in clock cycles; must be ≥ 1.
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enche`  in  1: fill valve open.
- `esvazia`  in  1: drain pump on.
- `lava`  in  1: wash motor on.
- `centrifuga`  in  1: spin motor on.
- `cheio`  out  1: drum full (`nivel == NIVEL_MAX`).
- `tempo`  out  1: the active motor phase has run its full duration.
- `secar`  out  1: spin has completed with the drum empty; the clothes are dry.
- `nivel`  out  $clog2(NIVEL_MAX+1): current level, for debug and the bench.

## Operation
- Level counter `nivel`, range 0..NIVEL_MAX:
  - `enche && !esvazia`: +1 per cycle, saturating at NIVEL_MAX.
  - `esvazia && !enche`: −1 per cycle, saturating at 0.
  - Both asserted or neither asserted: hold.
- Phase FSM states: REPOUSO, LAVANDO, CENTRIFUGANDO, CONCLUIDO.
  - REPOUSO → LAVANDO when `lava && !centrifuga`. The timer loads T_LAVAGEM−1.
  - Any state except CENTRIFUGANDO → CENTRIFUGANDO when `centrifuga`. The timer loads T_CENTRIF−1. `centrifuga` has priority if both motors are asserted.
  - LAVANDO → REPOUSO when `lava` drops. The timer is abandoned and `tempo` clears.
  - CENTRIFUGANDO → CONCLUIDO when `centrifuga` drops after the timer has expired. If `centrifuga` drops before expiry, return to REPOUSO.
  - CONCLUIDO → REPOUSO when `enche` asserts.
  - CONCLUIDO → LAVANDO when `lava` asserts.
- Timer behaviour:
  - Counts down once per cycle while in LAVANDO or CENTRIFUGANDO.
  - Holds at 0 once expired.
- `tempo` is a level signal: 1 while in LAVANDO or CENTRIFUGANDO with the timer at 0 and the motor still on.
- `secar` is a level signal: 1 while in CONCLUIDO and `nivel == 0`. If water is added in CONCLUIDO, `secar` drops.
- Arithmetic: the level and timer are unsigned. No wrap-around is permitted in either direction.

## Timing
- All outputs are registered. A command sampled on edge N affects `nivel` and the FSM at edge N; outputs reflect the new state after edge N.
- From fill start, `cheio` rises after exactly NIVEL_MAX edges with `enche` held and the drum starting empty.
- `tempo` rises on the T-th edge after the motor was first sampled high (T = T_LAVAGEM or T_CENTRIF).
- `tempo` falls on the edge that samples the motor low.
- Reset values: `nivel`=0, FSM=REPOUSO, timer=0, and `cheio`=`tempo`=`secar`=0.
- Asserting `reset_n` mid-phase clears everything immediately (asynchronously). No partial level is retained.

## Configuration
- `MAQUINA_PLANTA_VAZAMENTO_EN` defined: adds parameter `T_VAZAMENTO` (default 16) and a leak.
  - A free-running leak counter decrements `nivel` by 1 every T_VAZAMENTO cycles when `nivel > 0` and `enche` is low.
  - The leak and the drain pump do not stack: at most −1 per cycle.
  - The leak counter resets to 0.
- Macro undefined: no leak logic, no extra parameter. The level changes only on `enche`/`esvazia`.

## Structure
- Shared package `maquina_pkg` contains:
  - the phase-state enum (REPOUSO, LAVANDO, CENTRIFUGANDO, CONCLUIDO);
  - default constants for NIVEL_MAX, T_LAVAGEM, T_CENTRIF and T_VAZAMENTO.
- The controller and its bench use the same package.
- One sub-module, `temporizador`: a loadable, saturating down-counter with `carga`, `valor` and `zero`, instantiated once for the phase timer.
- The leak counter, when enabled, reuses `temporizador` as a second instance.

## Test plan
- Reset with `reset_n`=0 for 10 time units, then release → all outputs 0, `nivel`=0.
- `enche`=1 held from empty, defaults → `nivel` counts 1..8, `cheio` rises on the 8th edge, `nivel` stays 8 with `enche` still high.
- `lava`=1 held for 14 cycles → `tempo`=0 for the first 11 edges, 1 from the 12th edge; `lava`=0 → `tempo`=0 on the next edge and FSM in REPOUSO.
- Spin sequence:
  - Stimulus: `nivel`=8; `esvazia`=1 for 8 cycles; then `centrifuga`=1 for 6 cycles, then 0.
  - Response: `tempo` rises on the 6th edge; after `centrifuga` falls, `secar`=1.
  - Stimulus: then `enche`=1.
  - Response: `secar` drops to 0.
- `enche`=`esvazia`=1 at `nivel`=4 → `nivel` holds 4. `lava`=`centrifuga`=1 together → FSM enters CENTRIFUGANDO and the timer loads 5.
- With the macro defined, `T_VAZAMENTO`=16, `nivel`=8, no commands → `nivel`=7 after 16 cycles and `cheio` drops. Without the macro → `nivel` stays 8.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared definitions for the washing-machine controller, its drum plant model and their benches.
package maquina_pkg;

  // Drum motor phase
  typedef enum logic [1:0] {
    REPOUSO       = 2'd0,
    LAVANDO       = 2'd1,
    CENTRIFUGANDO = 2'd2,
    CONCLUIDO     = 2'd3
  } fase_t;

  // Default plant constants
  localparam int unsigned NIVEL_MAX_PADRAO   = 8;
  localparam int unsigned T_LAVAGEM_PADRAO   = 12;
  localparam int unsigned T_CENTRIF_PADRAO   = 6;
  localparam int unsigned T_VAZAMENTO_PADRAO = 16;

  // Larger of two durations, used to size a shared timer
  function automatic int unsigned maior(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maquina_planta_temporizador.sv
// temporizador: loadable down-counter that saturates at zero.
// zero is the registered "count is 0" flag; zero_prox_c is the same flag for the
// value about to be loaded, so callers can register outputs in step with the count.
module temporizador #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic         zero,
  output logic         zero_prox_c
);

  logic [W-1:0] contagem;
  logic [W-1:0] contagem_prox;

  // Next count: load has priority, otherwise decrement without wrapping below 0
  always_comb begin
    contagem_prox = contagem;
    if (carga) begin
      contagem_prox = valor;
    end else if (conta && (contagem != '0)) begin
      contagem_prox = contagem - W'(1);
    end
  end

  assign zero_prox_c = (contagem_prox == '0);

  // Count register and its zero flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
      zero     <= 1'b1;
    end else begin
      contagem <= contagem_prox;
      zero     <= zero_prox_c;
    end
  end

endmodule

// File: rtl/maquina_planta.sv
// maquina_planta: drum plant model driven by the controller's actuator commands.
// Produces cheio/tempo/secar so the controller can run closed-loop.
// Optional leak: define MAQUINA_PLANTA_VAZAMENTO_EN to add parameter T_VAZAMENTO and
// a free-running leak that removes one level every T_VAZAMENTO cycles while not filling.
module maquina_planta
  import maquina_pkg::*;
#(
  parameter int unsigned NIVEL_MAX   = NIVEL_MAX_PADRAO,
  parameter int unsigned T_LAVAGEM   = T_LAVAGEM_PADRAO,
  parameter int unsigned T_CENTRIF   = T_CENTRIF_PADRAO
`ifdef MAQUINA_PLANTA_VAZAMENTO_EN
  ,
  parameter int unsigned T_VAZAMENTO = T_VAZAMENTO_PADRAO
`endif
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enche,
  input  logic                             esvazia,
  input  logic                             lava,
  input  logic                             centrifuga,
  output logic                             cheio,
  output logic                             tempo,
  output logic                             secar,
  output logic [$clog2(NIVEL_MAX+1)-1:0]   nivel
);

  localparam int unsigned NW   = $clog2(NIVEL_MAX + 1);
  localparam int unsigned TMAX = maior(T_LAVAGEM, T_CENTRIF);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  fase_t          estado;
  fase_t          estado_prox;
  logic           carga_fase;
  logic [TW-1:0]  valor_fase;
  logic           conta_fase;
  logic           zero_fase;
  logic           zero_fase_prox;
  logic [NW-1:0]  nivel_prox;
  logic           desce;
  logic           tempo_prox;

  // Phase timer: holds the remaining cycles of the active motor phase
  temporizador #(
    .W (TW)
  ) u_tempo_fase (
    .clock       (clock),
    .reset_n     (reset_n),
    .carga       (carga_fase),
    .valor       (valor_fase),
    .conta       (conta_fase),
    .zero        (zero_fase),
    .zero_prox_c (zero_fase_prox)
  );

`ifdef MAQUINA_PLANTA_VAZAMENTO_EN
  localparam int unsigned VW = (T_VAZAMENTO > 1) ? $clog2(T_VAZAMENTO) : 1;

  logic vaz_zero;
  logic vaz_zero_prox;

  // Leak period counter: reloads when it sits at 0, the leak fires as it reaches 0
  temporizador #(
    .W (VW)
  ) u_vazamento (
    .clock       (clock),
    .reset_n     (reset_n),
    .carga       (vaz_zero),
    .valor       (VW'(T_VAZAMENTO - 1)),
    .conta       (1'b1),
    .zero        (vaz_zero),
    .zero_prox_c (vaz_zero_prox)
  );

  // Drain pump or leak, never both in one cycle
  assign desce = !enche && (esvazia || vaz_zero_prox);
`else
  assign desce = esvazia && !enche;
`endif

  // Level update: +1 on fill, -1 on drain, saturating at both ends
  always_comb begin
    nivel_prox = nivel;
    if (enche && !esvazia) begin
      if (nivel != NW'(NIVEL_MAX)) begin
        nivel_prox = nivel + NW'(1);
      end
    end else if (desce) begin
      if (nivel != '0) begin
        nivel_prox = nivel - NW'(1);
      end
    end
  end

  // Phase FSM next-state and timer control; spin has priority over wash
  always_comb begin
    estado_prox = estado;
    carga_fase  = 1'b0;
    valor_fase  = '0;
    conta_fase  = 1'b0;
    case (estado)
      REPOUSO: begin
        if (centrifuga) begin
          estado_prox = CENTRIFUGANDO;
          carga_fase  = 1'b1;
          valor_fase  = TW'(T_CENTRIF - 1);
        end else if (lava) begin
          estado_prox = LAVANDO;
          carga_fase  = 1'b1;
          valor_fase  = TW'(T_LAVAGEM - 1);
        end
      end
      LAVANDO: begin
        if (centrifuga) begin
          estado_prox = CENTRIFUGANDO;
          carga_fase  = 1'b1;
          valor_fase  = TW'(T_CENTRIF - 1);
        end else if (!lava) begin
          estado_prox = REPOUSO;
        end else begin
          conta_fase  = 1'b1;
        end
      end
      CENTRIFUGANDO: begin
        if (!centrifuga) begin
          estado_prox = zero_fase ? CONCLUIDO : REPOUSO;
        end else begin
          conta_fase  = 1'b1;
        end
      end
      CONCLUIDO: begin
        if (centrifuga) begin
          estado_prox = CENTRIFUGANDO;
          carga_fase  = 1'b1;
          valor_fase  = TW'(T_CENTRIF - 1);
        end else if (lava) begin
          estado_prox = LAVANDO;
          carga_fase  = 1'b1;
          valor_fase  = TW'(T_LAVAGEM - 1);
        end else if (enche) begin
          estado_prox = REPOUSO;
        end
      end
      default: begin
        estado_prox = REPOUSO;
      end
    endcase
  end

  // Staying in a motor phase implies that motor is still on
  assign tempo_prox = ((estado_prox == LAVANDO) || (estado_prox == CENTRIFUGANDO)) && zero_fase_prox;

  // Phase state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= REPOUSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Level and sensor output registers, updated from the post-edge values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nivel <= '0;
      cheio <= 1'b0;
      tempo <= 1'b0;
      secar <= 1'b0;
    end else begin
      nivel <= nivel_prox;
      cheio <= (nivel_prox == NW'(NIVEL_MAX));
      tempo <= tempo_prox;
      secar <= (estado_prox == CONCLUIDO) && (nivel_prox == '0);
    end
  end

endmodule

// File: tb/tb_maquina_planta.sv
// Bench for maquina_planta: directed test-plan sequences followed by random commands,
// all checked against a cycle-counting reference model of the drum.
module tb_maquina_planta;

  localparam int NMAX = 8;
  localparam int TL   = 12;
  localparam int TC   = 6;
  localparam int TV   = 16;

  localparam int REP  = 0;
  localparam int LAV  = 1;
  localparam int CEN  = 2;
  localparam int CONC = 3;

  logic clock = 1'b0;
  logic reset_n;
  logic enche;
  logic esvazia;
  logic lava;
  logic centrifuga;
  logic cheio;
  logic tempo;
  logic secar;
  logic [$clog2(NMAX+1)-1:0] nivel;

  int checks = 0;
  int erros  = 0;

  // Reference model: level, phase, cycles the current motor has run, edges since reset
  int m_nivel;
  int m_fase;
  int m_ciclos;
  int m_borda;

  maquina_planta dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enche      (enche),
    .esvazia    (esvazia),
    .lava       (lava),
    .centrifuga (centrifuga),
    .cheio      (cheio),
    .tempo      (tempo),
    .secar      (secar),
    .nivel      (nivel)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    assert (obs === esp) else begin
      erros++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, esp);
    end
  endtask

  task automatic modelo_reset();
    m_nivel  = 0;
    m_fase   = REP;
    m_ciclos = 0;
    m_borda  = 0;
  endtask

  task automatic modelo_borda();
    m_borda++;
    if (enche && !esvazia) begin
      if (m_nivel < NMAX) m_nivel++;
    end else if (esvazia && !enche) begin
      if (m_nivel > 0) m_nivel--;
    end
`ifdef MAQUINA_PLANTA_VAZAMENTO_EN
    else if (!enche && m_nivel > 0 && (m_borda % TV) == 0) begin
      m_nivel--;
    end
`endif
    if (centrifuga) begin
      if (m_fase == CEN) m_ciclos++;
      else begin
        m_fase   = CEN;
        m_ciclos = 1;
      end
    end else begin
      case (m_fase)
        LAV: if (lava) m_ciclos++; else m_fase = REP;
        CEN: m_fase = (m_ciclos >= TC) ? CONC : REP;
        REP: if (lava) begin
          m_fase   = LAV;
          m_ciclos = 1;
        end
        default: if (lava) begin
          m_fase   = LAV;
          m_ciclos = 1;
        end else if (enche) begin
          m_fase = REP;
        end
      endcase
    end
  endtask

  task automatic verifica_tudo(input string tag);
    logic esp_tempo;
    esp_tempo = ((m_fase == LAV) && (m_ciclos >= TL)) || ((m_fase == CEN) && (m_ciclos >= TC));
    verifica($sformatf("%s.nivel", tag), 32'(nivel), 32'(m_nivel));
    verifica($sformatf("%s.cheio", tag), 32'(cheio), 32'(m_nivel == NMAX));
    verifica($sformatf("%s.tempo", tag), 32'(tempo), 32'(esp_tempo));
    verifica($sformatf("%s.secar", tag), 32'(secar), 32'((m_fase == CONC) && (m_nivel == 0)));
  endtask

  // One clock edge: model follows the sampled commands, outputs checked 1 unit later
  task automatic passo(input string tag);
    @(posedge clock);
    modelo_borda();
    #1;
    verifica_tudo(tag);
  endtask

  task automatic comandos(input logic e, input logic s, input logic l, input logic c);
    enche      = e;
    esvazia    = s;
    lava       = l;
    centrifuga = c;
  endtask

  initial begin
    comandos(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    modelo_reset();
    #10;
    reset_n = 1'b1;
    #2;
    verifica_tudo("reset");
    verifica("reset.nivel0", 32'(nivel), 32'd0);

    // Fill from empty: full on the 8th edge, then saturate
    comandos(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      passo($sformatf("enche%0d", i));
      if (i == NMAX - 1) verifica("enche.cheio_antes", 32'(cheio), 32'd0);
      if (i == NMAX)     verifica("enche.cheio_8", 32'(cheio), 32'd1);
    end
    verifica("enche.satura", 32'(nivel), 32'd8);

    // Wash held 14 cycles: tempo from the 12th edge, cleared when lava drops
    comandos(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      passo($sformatf("lava%0d", i));
      if (i == TL - 1) verifica("lava.tempo_11", 32'(tempo), 32'd0);
      if (i == TL)     verifica("lava.tempo_12", 32'(tempo), 32'd1);
    end
    comandos(1'b0, 1'b0, 1'b0, 1'b0);
    passo("lava_solta");
    verifica("lava.tempo_cai", 32'(tempo), 32'd0);

    // Drain, spin, then dry; refilling clears secar
    comandos(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) passo($sformatf("esvazia%0d", i));
    comandos(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      passo($sformatf("centrif%0d", i));
      if (i == TC - 1) verifica("centrif.tempo_5", 32'(tempo), 32'd0);
    end
    verifica("centrif.tempo_6", 32'(tempo), 32'd1);
    comandos(1'b0, 1'b0, 1'b0, 1'b0);
    passo("centrif_solta");
    verifica("seco", 32'(secar), 32'd1);
    comandos(1'b1, 1'b0, 1'b0, 1'b0);
    passo("reenche");
    verifica("seco.cai", 32'(secar), 32'd0);

    // Fill to 4, then fill+drain together holds
    for (int i = 1; i <= 3; i++) passo($sformatf("ate4_%0d", i));
    comandos(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) passo($sformatf("ambos%0d", i));
    verifica("ambos.nivel4", 32'(nivel), 32'd4);

    // Both motors: spin wins, tempo on the 6th edge
    comandos(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) passo($sformatf("motores%0d", i));
    comandos(1'b0, 1'b0, 1'b0, 1'b0);
    passo("motores_solta");

    // Full drum left alone: leak (when built in) or steady level
    comandos(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) passo($sformatf("reenche%0d", i));
    comandos(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) passo($sformatf("parado%0d", i));

    // Asynchronous reset in the middle of a wash
    comandos(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) passo($sformatf("pre_rst%0d", i));
    @(posedge clock);
    modelo_borda();
    #2;
    reset_n = 1'b0;
    #1;
    modelo_reset();
    verifica_tudo("rst_meio");
    comandos(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b1;
    passo("pos_rst");

    // Random command streams with persistence so phases can run to completion
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) enche      = ~enche;
      if ($urandom_range(0, 7) == 0) esvazia    = ~esvazia;
      if ($urandom_range(0, 11) == 0) lava      = ~lava;
      if ($urandom_range(0, 13) == 0) centrifuga = ~centrifuga;
      passo($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
